fast_square_sweep_ctrl: RTL and testbench
=========================================

FAST_SQUARE_SWEEP_CTRL -- requirements
Module: fast_square_sweep_ctrl

Interface
REQ-001 SHALL have parameter TICK_W, default 16, width of settle/record tick counters (1..16).
REQ-002 SHALL have parameter STEP_W, default 6, width of step index (1..8).
REQ-003 SHALL have parameter NUM_CH, default 2, number of record-enable channels (1..4).
REQ-004 SHALL have parameter CFG_ADDR, default 7'd100, serial address of config reg A; reg B is at CFG_ADDR+1.
REQ-005 SHALL have ports: clock  in  1  sole clock; all logic is clocked on its rising edge.
REQ-006 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: serial_strobe in 1, serial_addr in 7, serial_data in 32  settings bus write.
REQ-008 SHALL have ports: sync_in  in  1  debounced external sweep-restart request, level.
REQ-009 SHALL have ports: freq_step_out  out  1  one-cycle pulse advancing the external synthesiser.
REQ-010 SHALL have ports: rx_reset out 1, rx_next out 1  one-cycle pulses to the receive accumulator.
REQ-011 SHALL have ports: rx_record  out  NUM_CH  per-channel record enable.
REQ-012 SHALL have ports: step_idx out STEP_W, busy out 1, sweep_done out 1 (one-cycle pulse).

Function
REQ-013 Reg A SHALL be [TICK_W-1:0] record_ticks; reg B SHALL be [15:0] settle_ticks (low TICK_W bits used), [23:16] num_steps (low STEP_W bits used), [24] enable, [25] continuous, [31:28] ch_mask (low NUM_CH bits used).
REQ-014 Regs SHALL update on the cycle after serial_strobe with matching serial_addr; non-matching writes are ignored.
REQ-015 Working copies of record_ticks, settle_ticks, num_steps and ch_mask SHALL be loaded on entry to WAIT_SYNC and on every sweep wrap; writes mid-sweep do not affect the sweep in progress.
REQ-016 A loaded value of 0 for record_ticks, settle_ticks or num_steps SHALL be treated as 1.
REQ-017 FSM states SHALL be IDLE, WAIT_SYNC, SETTLE, RECORD, STEP, DONE.
REQ-018 IDLE: all outputs low; enable=1 -> WAIT_SYNC, with rx_reset pulsed in the transition cycle.
REQ-019 WAIT_SYNC: rising edge of sync_in (registered, 1 cycle detect) -> SETTLE, step_idx=0.
REQ-020 SETTLE: exactly settle_ticks cycles, then RECORD.
REQ-021 RECORD: rx_record = ch_mask for exactly record_ticks cycles, zero otherwise; then STEP.
REQ-022 STEP: one cycle with freq_step_out=1 and rx_next=1.
REQ-023 From STEP with step_idx < num_steps-1: step_idx increments, -> SETTLE.
REQ-024 From STEP with step_idx = num_steps-1: sweep_done pulses in that cycle, step_idx wraps to 0, reload per REQ-015; continuous=1 -> SETTLE, else -> DONE.
REQ-025 DONE: outputs low except step_idx=0; stays until enable=0, then -> IDLE.
REQ-026 sync_in rising edge in SETTLE, RECORD or STEP SHALL take priority: step_idx=0, counters cleared, rx_reset pulsed, -> SETTLE; no freq_step_out or sweep_done that cycle.
REQ-027 enable=0 in any state SHALL force IDLE next cycle, overriding sync_in; outputs low from that cycle.
REQ-028 busy SHALL be 1 in WAIT_SYNC, SETTLE, RECORD, STEP; 0 in IDLE, DONE.
REQ-029 Tick counters SHALL be TICK_W bits, count up from 0, and never wrap within a state.

Reset
REQ-030 reset SHALL asynchronously force IDLE, all config regs 0, counters 0, step_idx 0, all outputs 0.
REQ-031 reset asserted mid-sweep SHALL abort without any further freq_step_out, rx_next or sweep_done pulse.

Verification
REQ-032 record=4, settle=2, steps=3, mask=2'b11, enable, single-shot, sync edge -> 3 x (2 settle + 4 record + 1 step) cycles; 3 freq_step_out pulses; sweep_done coincident with third; DONE.
REQ-033 Same with continuous=1 -> step_idx sequence 0,1,2,0,1,... and sweep_done every 21 cycles.
REQ-034 record=0, settle=0, steps=0 -> single-cycle settle, single-cycle record, one step, sweep_done on first STEP.
REQ-035 sync edge during RECORD of step 2 -> rx_reset pulse, step_idx=0, no freq_step_out, fresh 2-cycle SETTLE.
REQ-036 Write record=8 mid-sweep -> current sweep keeps 4-tick records; next sweep uses 8; mask=2'b01 -> rx_record[1] stays 0.
REQ-037 Clear enable during SETTLE, and separately assert reset during RECORD -> IDLE next cycle / immediately, all outputs 0, no pulses.

Source files
------------

// File: rtl/fast_square_sweep_ctrl.sv
// Stepped-frequency sweep sequencer: settle / record / step per point, restartable by sync_in.
// All outputs registered (one cycle after the deciding edge); no backpressure, timing set by tick counts.
module fast_square_sweep_ctrl #(
    parameter int         TICK_W   = 16,
    parameter int         STEP_W   = 6,
    parameter int         NUM_CH   = 2,
    parameter logic [6:0] CFG_ADDR = 7'd100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              serial_strobe,
    input  logic [6:0]        serial_addr,
    input  logic [31:0]       serial_data,
    input  logic              sync_in,
    output logic              freq_step_out,
    output logic              rx_reset,
    output logic              rx_next,
    output logic [NUM_CH-1:0] rx_record,
    output logic [STEP_W-1:0] step_idx,
    output logic              busy,
    output logic              sweep_done
);

    typedef enum logic [2:0] {IDLE, WAIT_SYNC, SETTLE, RECORD, STEP, DONE} state_t;

    state_t            state;
    logic [TICK_W-1:0] cfg_record, cfg_settle;
    logic [STEP_W-1:0] cfg_steps;
    logic              cfg_enable, cfg_cont;
    logic [NUM_CH-1:0] cfg_mask;

    logic [TICK_W-1:0] w_record, w_settle, cnt;
    logic [STEP_W-1:0] w_steps;
    logic [NUM_CH-1:0] w_mask;

    logic [TICK_W-1:0] ld_record, ld_settle;
    logic [STEP_W-1:0] ld_steps;
    logic              sync_q, sync_rise;
    logic              settle_last, record_last, step_last;
    logic              unused_data;

    // Only some bus bits map to config fields.
    assign unused_data = ^serial_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_record <= '0;
            cfg_settle <= '0;
            cfg_steps  <= '0;
            cfg_enable <= 1'b0;
            cfg_cont   <= 1'b0;
            cfg_mask   <= '0;
        end else if (serial_strobe) begin
            if (serial_addr == CFG_ADDR)
                cfg_record <= serial_data[TICK_W-1:0];
            if (serial_addr == CFG_ADDR + 7'd1) begin
                cfg_settle <= serial_data[TICK_W-1:0];
                cfg_steps  <= serial_data[16 +: STEP_W];
                cfg_enable <= serial_data[24];
                cfg_cont   <= serial_data[25];
                cfg_mask   <= serial_data[28 +: NUM_CH];
            end
        end
    end

    // A programmed zero would stall a phase forever, so it runs as one tick.
    assign ld_record = (cfg_record == '0) ? TICK_W'(1) : cfg_record;
    assign ld_settle = (cfg_settle == '0) ? TICK_W'(1) : cfg_settle;
    assign ld_steps  = (cfg_steps  == '0) ? STEP_W'(1) : cfg_steps;

    assign sync_rise   = sync_in & ~sync_q;
    assign settle_last = (cnt == w_settle - TICK_W'(1));
    assign record_last = (cnt == w_record - TICK_W'(1));
    assign step_last   = (step_idx == w_steps - STEP_W'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            sync_q        <= 1'b0;
            cnt           <= '0;
            w_record      <= '0;
            w_settle      <= '0;
            w_steps       <= '0;
            w_mask        <= '0;
            freq_step_out <= 1'b0;
            rx_reset      <= 1'b0;
            rx_next       <= 1'b0;
            rx_record     <= '0;
            step_idx      <= '0;
            busy          <= 1'b0;
            sweep_done    <= 1'b0;
        end else begin
            sync_q        <= sync_in;
            freq_step_out <= 1'b0;
            rx_reset      <= 1'b0;
            rx_next       <= 1'b0;
            sweep_done    <= 1'b0;
            if (!cfg_enable) begin
                state     <= IDLE;
                cnt       <= '0;
                rx_record <= '0;
                step_idx  <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= WAIT_SYNC;
                        rx_reset <= 1'b1;
                        busy     <= 1'b1;
                        w_record <= ld_record;
                        w_settle <= ld_settle;
                        w_steps  <= ld_steps;
                        w_mask   <= cfg_mask;
                    end
                    WAIT_SYNC: begin
                        if (sync_rise) begin
                            state    <= SETTLE;
                            cnt      <= '0;
                            step_idx <= '0;
                        end
                    end
                    SETTLE, RECORD, STEP: begin
                        // A fresh sync edge restarts the sweep and wins over any phase change.
                        if (sync_rise) begin
                            state     <= SETTLE;
                            cnt       <= '0;
                            step_idx  <= '0;
                            rx_reset  <= 1'b1;
                            rx_record <= '0;
                        end else if (state == SETTLE) begin
                            if (settle_last) begin
                                state     <= RECORD;
                                cnt       <= '0;
                                rx_record <= w_mask;
                            end else begin
                                cnt <= cnt + TICK_W'(1);
                            end
                        end else if (state == RECORD) begin
                            if (record_last) begin
                                state         <= STEP;
                                cnt           <= '0;
                                rx_record     <= '0;
                                freq_step_out <= 1'b1;
                                rx_next       <= 1'b1;
                                sweep_done    <= step_last;
                            end else begin
                                cnt <= cnt + TICK_W'(1);
                            end
                        end else if (step_last) begin
                            step_idx <= '0;
                            w_record <= ld_record;
                            w_settle <= ld_settle;
                            w_steps  <= ld_steps;
                            w_mask   <= cfg_mask;
                            state    <= cfg_cont ? SETTLE : DONE;
                            busy     <= cfg_cont;
                        end else begin
                            step_idx <= step_idx + STEP_W'(1);
                            state    <= SETTLE;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Bench for fast_square_sweep_ctrl: timeline reference model, vector table, corner sequences, random runs.
module tb_fast_square_sweep_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        serial_strobe;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        sync_in;
    logic        freq_step_out, rx_reset, rx_next, busy, sweep_done;
    logic [1:0]  rx_record;
    logic [5:0]  step_idx;

    fast_square_sweep_ctrl dut (
        .clock(clock), .reset(reset),
        .serial_strobe(serial_strobe), .serial_addr(serial_addr), .serial_data(serial_data),
        .sync_in(sync_in), .freq_step_out(freq_step_out), .rx_reset(rx_reset), .rx_next(rx_next),
        .rx_record(rx_record), .step_idx(step_idx), .busy(busy), .sweep_done(sweep_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sweep position is a cycle offset t from sweep start;
    // step = t / P and phase = t % P with P = settle + record + 1.
    int         m_mode;     // 0 off, 1 armed, 2 running, 3 done
    int         m_t, m_s, m_r, m_n, m_p, m_ph, m_st;
    logic [1:0] m_mask;
    int         c_rec, c_set, c_steps;
    bit         c_en, c_cont, m_rise, m_rr;
    logic [1:0] c_mask;
    logic       m_sync_prev;
    logic [12:0] exp_vec, dut_vec;
    bit         e_fs, e_done, e_busy;
    logic [1:0] e_rec;
    logic [5:0] e_idx;

    assign dut_vec = {freq_step_out, rx_reset, rx_next, rx_record, step_idx, busy, sweep_done};

    task automatic m_load();
        m_r = (c_rec == 0) ? 1 : c_rec;
        m_s = (c_set == 0) ? 1 : c_set;
        m_n = (c_steps == 0) ? 1 : c_steps;
        m_mask = c_mask;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_t = 0; c_rec = 0; c_set = 0; c_steps = 0;
            c_en = 0; c_cont = 0; c_mask = 0; m_sync_prev = 0; exp_vec = '0;
        end else begin
            m_rise = sync_in && !m_sync_prev;
            m_rr = 0;
            if (!c_en) m_mode = 0;
            else case (m_mode)
                0: begin m_mode = 1; m_load(); m_rr = 1; end
                1: if (m_rise) begin m_mode = 2; m_t = 0; end
                2: if (m_rise) begin m_t = 0; m_rr = 1; end
                   else begin
                       m_t++;
                       if (m_t == m_n * (m_s + m_r + 1)) begin
                           if (c_cont) begin m_load(); m_t = 0; end
                           else m_mode = 3;
                       end
                   end
                default: ;
            endcase
            m_sync_prev = sync_in;
            if (serial_strobe && serial_addr == 7'd100) c_rec = int'(serial_data[15:0]);
            if (serial_strobe && serial_addr == 7'd101) begin
                c_set = int'(serial_data[15:0]);
                c_steps = int'(serial_data[21:16]);
                c_en = serial_data[24];
                c_cont = serial_data[25];
                c_mask = serial_data[29:28];
            end
            e_fs = 0; e_done = 0; e_rec = 0; e_idx = 0;
            e_busy = (m_mode == 1) || (m_mode == 2);
            if (m_mode == 2) begin
                m_p = m_s + m_r + 1;
                m_ph = m_t % m_p;
                m_st = m_t / m_p;
                e_rec = (m_ph >= m_s && m_ph < m_s + m_r) ? m_mask : 2'b00;
                e_fs = (m_ph == m_p - 1);
                e_done = e_fs && (m_st == m_n - 1);
                e_idx = 6'(m_st);
            end
            exp_vec = {e_fs, m_rr, e_fs, e_rec, e_idx, e_busy, e_done};
        end
    end

    always @(negedge clock) if (mon_en) check("model", 32'(dut_vec), 32'(exp_vec));

    function automatic logic [31:0] reg_b(input int settle, input int steps, input bit en,
                                          input bit cont, input logic [1:0] mask);
        return {2'b00, mask, 2'b00, cont, en, 8'(steps), 16'(settle)};
    endfunction

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic write(input logic [6:0] addr, input logic [31:0] data);
        serial_strobe = 1'b1; serial_addr = addr; serial_data = data;
        @(negedge clock);
        serial_strobe = 1'b0;
    endtask

    // Returns at the negedge of the first SETTLE cycle.
    task automatic start(input int rec, input int settle, input int steps, input bit cont,
                         input logic [1:0] mask);
        sync_in = 1'b0;
        write(7'd101, 32'd0);
        repeat (2) @(negedge clock);
        write(7'd100, 32'(rec));
        write(7'd101, reg_b(settle, steps, 1'b1, cont, mask));
        repeat (3) @(negedge clock);
        sync_in = 1'b1;
        @(negedge clock);
        sync_in = 1'b0;
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0: return freq_step_out;
            1: return rx_record != 2'b00;
            2: return sweep_done;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input string name);
        int k = 0;
        while (!cond(sel) && k < 300) begin @(negedge clock); k++; end
        check(name, 32'(cond(sel)), 32'd1);
    endtask

    task automatic run_len(output int len, output logic [1:0] val);
        val = rx_record; len = 0;
        while (rx_record != 2'b00 && len < 50) begin len++; @(negedge clock); end
    endtask

    typedef struct {
        int rec; int settle; int steps; logic [1:0] mask;
        int e_busy; int e_steps; int e_done; int e_rec0; int e_rec1;
    } vec_t;
    vec_t tbl[4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, len, nfs, nnx, ndn, nb, r0, r1;
        int done_at[$];
        int idx_seq[$];
        logic [1:0] val;
        int exp_idx[6] = '{0, 1, 2, 0, 1, 2};

        tbl[0] = '{4, 2, 3, 2'b11, 21, 3, 1, 12, 12};
        tbl[1] = '{0, 0, 0, 2'b11,  3, 1, 1,  1,  1};
        tbl[2] = '{1, 1, 2, 2'b01,  6, 2, 1,  2,  0};
        tbl[3] = '{3, 0, 4, 2'b10, 20, 4, 1,  0, 12};

        reset = 1'b1; serial_strobe = 1'b0; serial_addr = '0; serial_data = '0; sync_in = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_outputs", 32'(dut_vec), 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 4; i++) begin
            start(tbl[i].rec, tbl[i].settle, tbl[i].steps, 1'b0, tbl[i].mask);
            nb = 0; nfs = 0; ndn = 0; r0 = 0; r1 = 0; k = 0;
            while (busy && k < 400) begin
                nb++; nfs += freq_step_out; ndn += sweep_done;
                r0 += rx_record[0]; r1 += rx_record[1];
                k++;
                @(negedge clock);
            end
            check($sformatf("tbl%0d_timeout", i), 32'(k < 400), 32'd1);
            check($sformatf("tbl%0d_cycles", i), 32'(nb), 32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_steps", i), 32'(nfs), 32'(tbl[i].e_steps));
            check($sformatf("tbl%0d_done", i), 32'(ndn), 32'(tbl[i].e_done));
            check($sformatf("tbl%0d_rec0", i), 32'(r0), 32'(tbl[i].e_rec0));
            check($sformatf("tbl%0d_rec1", i), 32'(r1), 32'(tbl[i].e_rec1));
            check($sformatf("tbl%0d_done_idx", i), 32'(step_idx), 32'd0);
        end

        // Continuous: done every 21 cycles, step index 0,1,2,0,1,2
        start(4, 2, 3, 1'b1, 2'b11);
        for (int c = 0; c < 100; c++) begin
            if (freq_step_out) idx_seq.push_back(int'(step_idx));
            if (sweep_done) done_at.push_back(c);
            @(negedge clock);
        end
        check("cont_ndone", 32'(done_at.size() >= 3), 32'd1);
        if (done_at.size() >= 3) begin
            check("cont_first_done", 32'(done_at[0]), 32'd20);
            check("cont_period1", 32'(done_at[1] - done_at[0]), 32'd21);
            check("cont_period2", 32'(done_at[2] - done_at[1]), 32'd21);
        end
        check("cont_nidx", 32'(idx_seq.size() >= 6), 32'd1);
        if (idx_seq.size() >= 6)
            for (int j = 0; j < 6; j++) check($sformatf("cont_idx%0d", j), 32'(idx_seq[j]), 32'(exp_idx[j]));

        // Sync edge during the record phase of step 2
        start(4, 2, 3, 1'b0, 2'b11);
        k = 0;
        while (!(step_idx == 6'd2 && rx_record != 2'b00) && k < 100) begin @(negedge clock); k++; end
        check("resync_found", 32'(k < 100), 32'd1);
        sync_in = 1'b1;
        @(negedge clock);
        check("resync_rx_reset", 32'(rx_reset), 32'd1);
        check("resync_idx", 32'(step_idx), 32'd0);
        check("resync_no_step", 32'(freq_step_out), 32'd0);
        check("resync_rec_off", 32'(rx_record), 32'd0);
        sync_in = 1'b0;
        @(negedge clock);
        check("resync_settle2", 32'(rx_record), 32'd0);
        @(negedge clock);
        check("resync_record", 32'(rx_record), 32'd3);
        wait_sig(3, "resync_finish");

        // Mid-sweep reconfiguration applies only after the wrap
        start(4, 2, 3, 1'b1, 2'b11);
        write(7'd100, 32'd8);
        write(7'd101, reg_b(2, 3, 1'b1, 1'b1, 2'b01));
        wait_sig(0, "midwr_step");
        wait_sig(1, "midwr_rec_a");
        run_len(len, val);
        check("midwr_len_old", 32'(len), 32'd4);
        check("midwr_mask_old", 32'(val), 32'd3);
        wait_sig(2, "midwr_done");
        wait_sig(1, "midwr_rec_b");
        run_len(len, val);
        check("midwr_len_new", 32'(len), 32'd8);
        check("midwr_mask_new", 32'(val), 32'd1);

        // Enable cleared during SETTLE
        start(4, 6, 3, 1'b0, 2'b11);
        write(7'd101, reg_b(6, 3, 1'b0, 1'b0, 2'b11));
        @(negedge clock);
        check("disable_outputs", 32'(dut_vec), 32'd0);
        nfs = 0; nnx = 0; ndn = 0; nb = 0;
        repeat (10) begin
            nfs += freq_step_out; nnx += rx_next; ndn += sweep_done; nb += busy;
            @(negedge clock);
        end
        check("disable_pulses", 32'(nfs + nnx + ndn + nb), 32'd0);

        // Reset asserted during RECORD
        start(4, 2, 3, 1'b0, 2'b11);
        wait_sig(1, "rst_rec");
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check("rst_async", 32'(dut_vec), 32'd0);
        nfs = 0; nnx = 0; ndn = 0;
        repeat (4) begin
            @(negedge clock);
            nfs += freq_step_out; nnx += rx_next; ndn += sweep_done;
        end
        check("rst_pulses", 32'(nfs + nnx + ndn), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("rst_cfg_cleared", 32'(busy), 32'd0);

        // Random runs against the model
        for (int r = 0; r < 8; r++) begin
            start($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 4),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 24) == 0) sync_in = ~sync_in;
                if ($urandom_range(0, 39) == 0) begin
                    write(7'd100, 32'($urandom_range(0, 5)));
                end else if ($urandom_range(0, 59) == 0) begin
                    write(7'd101, reg_b($urandom_range(0, 3), $urandom_range(0, 4),
                                        $urandom_range(0, 5) != 0, 1'($urandom_range(0, 1)),
                                        2'($urandom_range(0, 3))));
                end else begin
                    @(negedge clock);
                end
            end
        end

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
